serial_adder: RTL and testbench

- Bit-serial unsigned adder built around the team's half-adder primitive, extended with a registered carry to form a full-adder slice.
- Captures two WIDTH-bit operands on a start pulse and adds them one bit per clock, LSB first.
- Presents a registered sum/carry with a one-cycle done pulse.
- Sits directly downstream of the half-adder cell in the arithmetic chain. It trades area for latency where a ripple adder is too large.

---
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice plus registered carry, LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add a registered signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, psum, psum_nx;
  logic [CW-1:0]    cnt;
  logic             c, s, c_nx;
  logic             h1, g1, g2;
  logic             last, load;

  // Full adder built from two half-adder cells.
  always_comb begin
    h1      = a_sr[0] ^ b_sr[0];
    g1      = a_sr[0] & b_sr[0];
    s       = h1 ^ c;
    g2      = h1 & c;
    c_nx    = g1 | g2;
    psum_nx = (psum >> 1) | (WIDTH'(s) << (WIDTH - 1));
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      psum <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      psum <= psum_nx;
      c    <= c_nx;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum   <= psum_nx;
        carry <= c_nx;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        // c is the carry into the MSB on this final bit.
        overflow <= c ^ c_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=4 and WIDTH=1 instances).
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         busy1, done1, carry1;
  logic [0:0]   sum1;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic overflow, overflow1;
`endif

  int n_chk = 0;
  int n_pass = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .sum(sum), .carry(carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .sum(sum1), .carry(carry1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(overflow1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; result checked in the DONE cycle on return.
  task automatic run_add(input string tag,
                         input logic [W-1:0] va,
                         input logic [W-1:0] vb,
                         input logic [W-1:0] es,
                         input logic ec,
                         input logic eo);
    start = 1'b1;
    a = va;
    b = vb;
    tick();
    start = 1'b0;
    a = ~va;
    b = ~vb;
    check({tag, " busy0"}, 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      tick();
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " nodone"}, 32'(done), 32'd0);
    end
    tick();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " carry"}, 32'(carry), 32'(ec));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, " ovf"}, 32'(overflow), 32'(eo));
`else
    if (eo === 1'bx) $display("note: ovf unused");
`endif
  endtask

  task automatic settle(input string tag);
    tick();
    check({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst carry", 32'(carry), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    run_add("3+5", 4'd3, 4'd5, 4'd8, 1'b0, 1'b1);
    settle("3+5");
    run_add("15+1", 4'd15, 4'd1, 4'd0, 1'b1, 1'b0);
    settle("15+1");
    run_add("15+15", 4'd15, 4'd15, 4'd14, 1'b1, 1'b0);
    settle("15+15");
    run_add("0+0", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    settle("0+0");

    // start held through RUN, operand changed after capture
    start = 1'b1;
    a = 4'd2;
    b = 4'd2;
    tick();
    a = 4'd9;
    check("hold busy0", 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      tick();
      check("hold busy", 32'(busy), 32'd1);
      check("hold nodone", 32'(done), 32'd0);
    end
    tick();
    check("hold done", 32'(done), 32'd1);
    check("hold sum", 32'(sum), 32'd4);
    check("hold carry", 32'(carry), 32'd0);
    tick();
    check("re busy", 32'(busy), 32'd1);
    check("re nodone", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 1; i < W; i++) begin
      tick();
      check("re busy", 32'(busy), 32'd1);
    end
    tick();
    check("re done", 32'(done), 32'd1);
    check("re sum", 32'(sum), 32'd11);
    check("re carry", 32'(carry), 32'd0);

    // back-to-back from the DONE cycle
    run_add("6+7", 4'd6, 4'd7, 4'd13, 1'b0, 1'b1);
    settle("6+7");

    // reset in the middle of RUN
    start = 1'b1;
    a = 4'd9;
    b = 4'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort carry", 32'(carry), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort nodone", 32'(done), 32'd0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("post idle", 32'(busy), 32'd0);
    run_add("1+1", 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    settle("1+1");

    run_add("7+1", 4'd7, 4'd1, 4'd8, 1'b0, 1'b1);
    settle("7+1");
    run_add("8+8", 4'd8, 4'd8, 4'd0, 1'b1, 1'b1);
    settle("8+8");
    run_add("3+2", 4'd3, 4'd2, 4'd5, 1'b0, 1'b0);
    settle("3+2");

    // single-bit instance: exactly one RUN cycle
    start1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1 busy", 32'(busy1), 32'd1);
    tick();
    check("w1 done", 32'(done1), 32'd1);
    check("w1 idle", 32'(busy1), 32'd0);
    check("w1 sum", 32'(sum1), 32'd0);
    check("w1 carry", 32'(carry1), 32'd1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("w1 ovf", 32'(overflow1), 32'd1);
`endif
    tick();
    check("w1 pulse", 32'(done1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
